// File: rtl/random_roller.sv
// ============================================================================
// Module      : random_roller
// Description : LFSR-driven dice-style roller. On start it resamples its
//               output at a decelerating rate, then freezes on a final value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module random_roller #(
  parameter int TICK_DIV      = 5_000_000,
  parameter int STAGES        = 8,
  parameter int STAGE_UPDATES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_stop,
  output logic [12:0] o_val,
  output logic        o_rolling,
  output logic        o_done
);

  localparam int              PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] C_PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [3:0]      C_ST_MAX  = 4'(STAGES - 1);
  localparam logic [3:0]      C_UP_MAX  = 4'(STAGE_UPDATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROLL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [12:0]        r_lfsr;
  logic               w_fb;
  logic [PRE_W-1:0]   r_pre;
  logic [PRE_W-1:0]   w_pre_nxt;
  logic [3:0]         r_tk;
  logic [3:0]         w_tk_nxt;
  logic [3:0]         r_up;
  logic [3:0]         w_up_nxt;
  logic [3:0]         r_st;
  logic [3:0]         w_st_nxt;
  logic               w_sample;
  logic               w_done_nxt;
  logic [12:0]        r_val;
  logic               r_rolling;
  logic               r_done;

  // x^13+x^4+x^3+x+1, maximal length so the value is never zero
  assign w_fb = r_lfsr[12] ^ r_lfsr[3] ^ r_lfsr[2] ^ r_lfsr[0];

  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_tk_nxt    = r_tk;
    w_up_nxt    = r_up;
    w_st_nxt    = r_st;
    w_sample    = 1'b0;
    w_done_nxt  = 1'b0;

    if (i_start) begin
      // start from any state, including a restart mid-roll
      w_state_nxt = S_ROLL;
      w_sample    = 1'b1;
      w_pre_nxt   = '0;
      w_tk_nxt    = '0;
      w_up_nxt    = '0;
      w_st_nxt    = '0;
    end else if (r_state == S_ROLL) begin
      if (i_stop) begin
        w_state_nxt = S_DONE;
        w_sample    = 1'b1;
        w_done_nxt  = 1'b1;
      end else if (r_pre == C_PRE_MAX) begin
        w_pre_nxt = '0;
        if (r_tk == r_st) begin
          w_sample = 1'b1;
          w_tk_nxt = '0;
          if (r_up == C_UP_MAX) begin
            w_up_nxt = '0;
            if (r_st == C_ST_MAX) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_st_nxt = r_st + 4'd1;
            end
          end else begin
            w_up_nxt = r_up + 4'd1;
          end
        end else begin
          w_tk_nxt = r_tk + 4'd1;
        end
      end else begin
        w_pre_nxt = r_pre + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_lfsr    <= 13'h0001;
      r_pre     <= '0;
      r_tk      <= '0;
      r_up      <= '0;
      r_st      <= '0;
      r_val     <= '0;
      r_rolling <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lfsr    <= {r_lfsr[11:0], w_fb};
      r_pre     <= w_pre_nxt;
      r_tk      <= w_tk_nxt;
      r_up      <= w_up_nxt;
      r_st      <= w_st_nxt;
      r_rolling <= (w_state_nxt == S_ROLL);
      r_done    <= w_done_nxt;
      if (w_sample) begin
        r_val <= r_lfsr;
      end
    end
  end

  assign o_val     = r_val;
  assign o_rolling = r_rolling;
  assign o_done    = r_done;

endmodule

`default_nettype wire
